tt_pin_cmd_responder: RTL and testbench
=======================================

# tt_pin_cmd_responder

Device-side responder for the host pin protocol that the cocotb bench drives through `ui_in`/`uio_in`. It synchronises a host strobe, decodes a read/write command into an 8-entry byte register file, and answers on `uo_out`/`uio_out` with a four-phase ack handshake. It sits directly behind the top-level pins inside `tt_um_alyza05_digi_logic`. Register 0 is mirrored onto the user outputs for downstream logic.

## Interface
- `SYNC_STAGES`, 2: strobe synchroniser depth, ≥2.
- `ID_VALUE`, 8'hA5: constant returned by register 7.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  design selected; while low, new strobes are ignored.
- `ui_in`  in  8  [7] strobe, [6] 1=write/0=read, [5:3] address, [2:0] reserved, ignored.
- `uio_in`  in  8  write data.
- `uo_out`  out  8  [7] ack, [6] err, [5:0] reg0[5:0].
- `uio_out`  out  8  read data.
- `uio_oe`  out  8  8'hFF while read data is driven, else 8'h00.

## Operation
- Register map:
  - 0–5 are R/W, reset 0.
  - 6 is a read-only transaction counter, reset 0, 8-bit wrap 255→0.
  - 7 is read-only and returns `ID_VALUE`.
- Strobe passes a `SYNC_STAGES`-flop synchroniser (reset 0). `srise` = synced strobe high, previous synced low. `sfall` is the inverse.
- FSM states:
  - RESYNC (reset state): go to IDLE on the first cycle the synced strobe is low. This prevents a strobe held across reset from being taken as a new command.
  - IDLE: on `srise` && `ena`, capture `ui_in[6:3]` and `uio_in` into holding registers directly from the pins, then go to EXEC. `srise` with `ena`=0 goes to RELEASE with no ack.
  - EXEC (1 cycle), then ACK:
    - Write to 0–5: update the register.
    - Write to 6/7: no update, set err.
    - Read: load `uio_out` ← reg[addr], `uio_oe` ← FF.
    - Any legal transaction: clear err.
    - Every acked transaction, legal or illegal: increment reg6.
  - ACK: ack=1. Hold `uio_out`/`uio_oe` (read) unchanged. On `sfall`: ack=0, `uio_oe`=00, go to IDLE.
  - RELEASE: wait for `sfall` → IDLE, no outputs change.
- err is sticky until the next acked legal transaction. A write to 6/7 while err=1 keeps err=1.
- Reading reg6 returns the value before that read's own increment.
- Strobe rising again while in ACK cannot occur legally. No new command is accepted before `sfall` → IDLE.
- Reset values:
  - All outputs 0, so `uo_out`=00, `uio_out`=00, `uio_oe`=00.
  - regs 0–6 = 0, err = 0, state = RESYNC.

## Timing
- Host requirement: `ui_in[6:3]` and `uio_in` stable from strobe rise until ack is seen high.
- Strobe first sampled high at edge k:
  - with `SYNC_STAGES`=2, `srise` is valid in the cycle after edge k+1;
  - capture happens at edge k+2;
  - EXEC at edge k+3;
  - ack, read data and `uio_oe` are visible after edge k+3.
- Generalised latency is `SYNC_STAGES`+1 edges.
- Release: strobe first sampled low at edge m → ack and `uio_oe` drop after edge m+`SYNC_STAGES`.
- Write effect on `uo_out[5:0]` (reg0 writes) is visible in the same cycle as ack.
- Asynchronous `rst` mid-transaction clears outputs immediately. If the strobe is still high at release, the FSM stays in RESYNC until the strobe is seen low, and no ack is issued for that strobe.
- Minimum transaction with strobe high ≥ 3 cycles and low ≥ 3 cycles: 6 clocks plus host response time.

## Test plan
- Reset, then write addr 0 data 8'h3C, then read addr 0:
  - ack pulses for each transaction;
  - after the write, `uo_out`=8'h3C (ack=0);
  - the read gives `uio_out`=3C, `uio_oe`=FF while ack=1, then 00 after release;
  - reg6 reads 2 on a subsequent read.
- Read addr 7 → `uio_out`=A5. Write addr 7 data 8'h00 → ack with err=1 and reg7 unchanged. A following legal write to addr 1 clears err to 0.
- Latency check: strobe asserted at edge k → ack first high after edge k+3, not earlier. Strobe dropped at edge m → ack low after edge m+2.
- `ena`=0 during a strobe:
  - no ack, no register change, reg6 unchanged;
  - then `ena`=1 with a new strobe is processed normally.
- Assert `rst` while in ACK with the strobe held high, then release:
  - outputs are 0 and no ack occurs while the strobe stays high;
  - after strobe low then high, a read of addr 6 returns 0.
- 256 acked transactions from reset → reg6 wraps to 0. A read issued after exactly 256 acked transactions returns 8'h00.

Source files
------------

// File: rtl/tt_pin_cmd_responder.sv
// tt_pin_cmd_responder: synchronised-strobe read/write decoder into an 8-entry byte register file with four-phase ack.
module tt_pin_cmd_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {RESYNC, IDLE, EXEC, ACK, RELEASE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic prev_q;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic ack_q, ack_d, oe_q, oe_d, err_q, err_d;
  logic synced, srise, sfall, wr;
  logic [2:0] addr;
  logic [7:0] rd_val;
  logic unused_ok;
  assign unused_ok = ^ui_in[2:0];
  assign synced = sync_q[SYNC_STAGES-1];
  assign srise = synced & ~prev_q;
  assign sfall = ~synced & prev_q;
  assign wr = cmd_q[3];
  assign addr = cmd_q[2:0];
  assign rd_val = addr == 3'd7 ? ID_VALUE : addr == 3'd6 ? cnt_q : regs_q[addr];
  assign uo_out = {ack_q, err_q, regs_q[0][5:0]};
  assign uio_out = rdata_q;
  assign uio_oe = {8{oe_q}};
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    regs_d = regs_q;
    ack_d = ack_q;
    oe_d = oe_q;
    err_d = err_q;
    case (state_q)
      // fill_q gates the exit so a strobe held through reset is seen high before RESYNC can leave
      RESYNC: if (fill_q[SYNC_STAGES-1] && !synced) state_d = IDLE;
      IDLE: if (srise) begin
        state_d = ena ? EXEC : RELEASE;
        cmd_d = ena ? ui_in[6:3] : cmd_q;
        wdata_d = ena ? uio_in : wdata_q;
      end
      EXEC: begin
        state_d = ACK;
        ack_d = 1'b1;
        cnt_d = cnt_q + 8'd1;
        err_d = wr && addr >= 3'd6;
        oe_d = !wr;
        rdata_d = wr ? rdata_q : rd_val;
        if (wr && addr < 3'd6) regs_d[addr] = wdata_q;
      end
      ACK: if (sfall) begin
        state_d = IDLE;
        ack_d = 1'b0;
        oe_d = 1'b0;
        rdata_d = 8'h00;
      end
      RELEASE: if (sfall) state_d = IDLE;
      default: state_d = RESYNC;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESYNC;
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      cmd_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      regs_q <= '{default: '0};
      ack_q <= 1'b0;
      oe_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[7]};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= synced;
      cmd_q <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
      ack_q <= ack_d;
      oe_q <= oe_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_tt_pin_cmd_responder.sv
// tb_tt_pin_cmd_responder: randomized transactions against a register-map reference model.
module tb_tt_pin_cmd_responder;
  localparam logic [7:0] ID = 8'hA5;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_regs [6];
  logic [7:0] m_cnt;
  logic m_err;

  tt_pin_cmd_responder dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
    m_cnt = 8'h00;
    m_err = 1'b0;
  endfunction

  function automatic logic [7:0] model_txn(input bit w, input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    if (w) begin
      if (a < 3'd6) m_regs[a] = d;
      m_err = a >= 3'd6;
    end else begin
      r = a == 3'd7 ? ID : a == 3'd6 ? m_cnt : m_regs[a];
      m_err = 1'b0;
    end
    m_cnt = m_cnt + 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] exp_uo(input bit ack);
    return {ack, m_err, m_regs[0][5:0]};
  endfunction

  task automatic do_txn(input bit w, input logic [2:0] a, input logic [7:0] d, output bit ok,
                        output logic [7:0] uo_ack, output logic [7:0] rd, output logic [7:0] oe_ack,
                        output logic [7:0] uo_rel, output logic [7:0] oe_rel);
    int n;
    @(negedge clk);
    ui_in = {1'b1, w, a, 3'($urandom)};
    uio_in = d;
    n = 0;
    while (!uo_out[7] && n < 20) begin @(negedge clk); n++; end
    ok = uo_out[7];
    uo_ack = uo_out;
    rd = uio_out;
    oe_ack = uio_oe;
    ui_in[7] = 1'b0;
    n = 0;
    while (uo_out[7] && n < 20) begin @(negedge clk); n++; end
    ok = ok && !uo_out[7];
    uo_rel = uo_out;
    oe_rel = uio_oe;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo got=%h exp=00", uo_out); end
    n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
    n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL reset_oe got=%h exp=00", uio_oe); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] ua, rd, oa, ur, orl, e;
    e = model_txn(1'b1, 3'd0, 8'h3C);
    do_txn(1'b1, 3'd0, 8'h3C, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr0_handshake got=0 exp=1"); end
    n_cmp++; if (ua !== exp_uo(1'b1)) begin n_bad++; $display("FAIL wr0_uo_at_ack got=%h exp=%h", ua, exp_uo(1'b1)); end
    n_cmp++; if (ur !== 8'h3C) begin n_bad++; $display("FAIL wr0_uo_after got=%h exp=3c", ur); end
    e = model_txn(1'b0, 3'd0, 8'h00);
    do_txn(1'b0, 3'd0, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd0_handshake got=0 exp=1"); end
    n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL rd0_data got=%h exp=3c", rd); end
    n_cmp++; if (oa !== 8'hFF) begin n_bad++; $display("FAIL rd0_oe got=%h exp=ff", oa); end
    n_cmp++; if (orl !== 8'h00) begin n_bad++; $display("FAIL rd0_oe_release got=%h exp=00", orl); end
    e = model_txn(1'b0, 3'd6, 8'h00);
    do_txn(1'b0, 3'd6, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (rd !== 8'd2 || rd !== e) begin n_bad++; $display("FAIL rd6_count got=%h exp=%h", rd, e); end
  endtask

  task automatic test_id_err();
    bit ok;
    logic [7:0] ua, rd, oa, ur, orl, e;
    e = model_txn(1'b0, 3'd7, 8'h00);
    do_txn(1'b0, 3'd7, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (rd !== ID) begin n_bad++; $display("FAIL rd7_id got=%h exp=%h", rd, ID); end
    e = model_txn(1'b1, 3'd7, 8'h00);
    do_txn(1'b1, 3'd7, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (!ok || ua[6] !== 1'b1) begin n_bad++; $display("FAIL wr7_err got=%b exp=1", ua[6]); end
    e = model_txn(1'b1, 3'd6, 8'h55);
    do_txn(1'b1, 3'd6, 8'h55, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (ur[6] !== 1'b1) begin n_bad++; $display("FAIL wr6_err_sticky got=%b exp=1", ur[6]); end
    e = model_txn(1'b1, 3'd1, 8'h77);
    do_txn(1'b1, 3'd1, 8'h77, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (ua[6] !== 1'b0) begin n_bad++; $display("FAIL wr1_err_clear got=%b exp=0", ua[6]); end
    e = model_txn(1'b0, 3'd7, 8'h00);
    do_txn(1'b0, 3'd7, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rd7_unchanged got=%h exp=%h", rd, e); end
  endtask

  task automatic test_latency();
    logic [7:0] e;
    e = model_txn(1'b0, 3'd1, 8'h00);
    @(negedge clk);
    ui_in = {1'b1, 1'b0, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (uo_out[7] !== (i == 3)) begin n_bad++; $display("FAIL lat_rise_k+%0d got=%b exp=%b", i, uo_out[7], i == 3); end
    end
    n_cmp++; if (uio_out !== e) begin n_bad++; $display("FAIL lat_rdata got=%h exp=%h", uio_out, e); end
    @(negedge clk);
    ui_in[7] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (uo_out[7] !== (i < 2)) begin n_bad++; $display("FAIL lat_fall_m+%0d got=%b exp=%b", i, uo_out[7], i < 2); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ena();
    bit ok, seen;
    logic [7:0] ua, rd, oa, ur, orl, e;
    @(negedge clk);
    ena = 1'b0;
    ui_in = {1'b1, 1'b1, 3'd2, 3'd0};
    uio_in = 8'hEE;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= uo_out[7]; end
    ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ena0_no_ack got=%b exp=0", seen); end
    e = model_txn(1'b0, 3'd2, 8'h00);
    do_txn(1'b0, 3'd2, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (!ok || rd !== e) begin n_bad++; $display("FAIL ena0_reg2 got=%h exp=%h", rd, e); end
    e = model_txn(1'b0, 3'd6, 8'h00);
    do_txn(1'b0, 3'd6, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL ena0_count got=%h exp=%h", rd, e); end
  endtask

  task automatic test_rst_in_ack();
    bit ok, seen;
    int n;
    logic [7:0] ua, rd, oa, ur, orl, e;
    @(negedge clk);
    ui_in = {1'b1, 1'b0, 3'd0, 3'd0};
    n = 0;
    while (!uo_out[7] && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (uo_out[7] !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ack got=%b exp=1", uo_out[7]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({uo_out, uio_out, uio_oe} !== 24'h0) begin n_bad++; $display("FAIL rst_async_clear got=%h exp=000000", {uo_out, uio_out, uio_oe}); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= uo_out[7]; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_held_strobe_ack got=%b exp=0", seen); end
    ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);
    e = model_txn(1'b0, 3'd6, 8'h00);
    do_txn(1'b0, 3'd6, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (!ok || rd !== 8'h00 || rd !== e) begin n_bad++; $display("FAIL rst_count got=%h exp=00", rd); end
  endtask

  task automatic test_random();
    bit ok, w;
    logic [2:0] a;
    logic [7:0] d, ua, rd, oa, ur, orl, e;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = 3'($urandom);
      d = 8'($urandom);
      e = model_txn(w, a, d);
      do_txn(w, a, d, ok, ua, rd, oa, ur, orl);
      n_cmp++; if (!ok || ua !== exp_uo(1'b1)) begin n_bad++; $display("FAIL rand%0d_uo got=%h exp=%h", i, ua, exp_uo(1'b1)); end
      n_cmp++; if (oa !== (w ? 8'h00 : 8'hFF) || orl !== 8'h00) begin n_bad++; $display("FAIL rand%0d_oe got=%h/%h exp=%h/00", i, oa, orl, w ? 8'h00 : 8'hFF); end
      if (!w) begin
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rand%0d_rdata a=%0d got=%h exp=%h", i, a, rd, e); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int lost;
    logic [2:0] a;
    logic [7:0] d, ua, rd, oa, ur, orl, e;
    pulse_reset();
    lost = 0;
    for (int i = 0; i < 256; i++) begin
      a = 3'($urandom_range(0, 5));
      d = 8'($urandom);
      e = model_txn(1'b1, a, d);
      do_txn(1'b1, a, d, ok, ua, rd, oa, ur, orl);
      if (!ok) lost++;
    end
    n_cmp++; if (lost !== 0) begin n_bad++; $display("FAIL wrap_handshakes got=%0d lost exp=0", lost); end
    e = model_txn(1'b0, 3'd6, 8'h00);
    do_txn(1'b0, 3'd6, 8'h00, ok, ua, rd, oa, ur, orl);
    n_cmp++; if (rd !== 8'h00 || rd !== e) begin n_bad++; $display("FAIL wrap_count got=%h exp=00", rd); end
    n_cmp++; if (ua[5:0] !== m_regs[0][5:0]) begin n_bad++; $display("FAIL wrap_reg0 got=%h exp=%h", ua[5:0], m_regs[0][5:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_id_err();
    test_latency();
    test_ena();
    test_rst_in_ack();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
